sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-port SRAM model (ren/wen level-request, rvalid/bvalid response).
- Master 0 is the IFU (read-only in practice).
- Master 1 is the LSU (read/write).
- Each master gets a valid/ready request channel and a valid/ready response channel.
- The block serialises accesses, holds the SRAM request level until the response arrives, and inserts the idle cycle the SRAM needs to clear its response flags.

Parameters:
ADDR_WIDTH, 32, address width for both masters and the SRAM port
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
clk  in  1  clock, single clock domain
rst_n  in  1  asynchronous reset, active-low
mX_req_valid  in  1  request valid (X = 0, 1; one set of request/response ports per master)
mX_req_ready  out  1  request accepted this cycle
mX_req_write  in  1  1 = write, 0 = read
mX_req_addr  in  ADDR_WIDTH  byte address
mX_req_wdata  in  DATA_WIDTH  write data
mX_req_wstrb  in  DATA_WIDTH/8  byte strobes
mX_resp_valid  out  1  response valid
mX_resp_ready  in  1  master takes response
mX_resp_rdata  out  DATA_WIDTH  read data; 0 for writes
mX_resp_err  out  2  SRAM rresp/bresp passthrough
s_araddr  out  ADDR_WIDTH  to SRAM araddr
s_ren  out  1  to SRAM ren
s_rdata  in  DATA_WIDTH  from SRAM rdata
s_rresp  in  2  from SRAM rresp
s_rvalid  in  1  from SRAM rvalid
s_awaddr  out  ADDR_WIDTH  to SRAM awaddr
s_wdata  out  DATA_WIDTH  to SRAM wdata
s_wen  out  1  to SRAM wen
s_wstrb  out  DATA_WIDTH/8  to SRAM wstrb
s_bresp  in  2  from SRAM bresp
s_bvalid  in  1  from SRAM bvalid

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state IDLE, grant register 0, round-robin pointer points to m0.
  - Reset mid-operation aborts the access; no response is delivered.
- FSM states: IDLE, ACCESS, RESP, GAP.
- IDLE:
  - Pick a winner among asserted mX_req_valid.
  - mX_req_ready is combinational, high only for the winner and only in IDLE.
  - On handshake, latch write/addr/wdata/wstrb and the grant, then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - Drive s_ren = !write, s_wen = write, plus latched address/data/strobe; hold them stable every cycle.
  - Never assert s_ren and s_wen together.
  - On s_rvalid (read) or s_bvalid (write): capture rdata (0 for writes) and resp, drop s_ren/s_wen in the next cycle, go to RESP.
  - No timeout; the SRAM delay is unbounded.
- RESP:
  - Assert mX_resp_valid for the granted master only; data and err are stable while valid.
  - On resp_ready, go to GAP.
  - The response may be held any number of cycles.
  - s_ren and s_wen stay 0 in RESP.
- GAP:
  - Exactly one cycle with s_ren = s_wen = 0 so the SRAM clears rvalid/bvalid, then go to IDLE.
  - No request is accepted in GAP.
- Latency: accept at cycle T; ACCESS T+1..T+D+1 (D = SRAM delay); resp_valid from the cycle after s_rvalid/s_bvalid is sampled.
  - Minimum issue-to-issue spacing is D+4 cycles.
- Simultaneous requests in IDLE: without the optional feature, m1 (LSU) always wins.
- A master that drops req_valid before ready is simply not served (no error).
- Outstanding transactions: at most one in total.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: on a simultaneous request, the master not granted last wins.
  - The pointer updates on every accepted request.
- Undefined: fixed priority, m1 over m0; the pointer logic is absent.

Decomposition:
- Shared package:
  - state enum {IDLE, ACCESS, RESP, GAP}
  - response code constant RESP_OKAY = 2'b00
  - master index constants M_IFU = 0, M_LSU = 1
- One sub-module, arb_picker: combinational winner selection from two valids plus the last-grant pointer; round-robin or fixed priority per the macro.

Test Plan:
- m0 read addr 0x8000_0000, SRAM delay 3, rdata 0xDEAD_BEEF -> s_ren high exactly during ACCESS; m0_resp_valid with rdata 0xDEAD_BEEF, err 0; one GAP cycle with s_ren = 0 before the next accept.
- m1 write addr 0x8000_0010, wdata 0x1234_5678, wstrb 4'b0011 -> s_wen held until s_bvalid; awaddr/wdata/wstrb stable; m1 response rdata 0.
- m0 and m1 both valid every cycle for 6 transactions -> macro off: all six grants to m1, m0 starved; macro on: grants alternate m1, m0, m1, m0, m1, m0.
- m0 holds resp_ready low for 5 cycles while m1 requests -> response held stable; m1_req_ready stays 0 until RESP→GAP→IDLE completes.
- rst_n pulsed low during ACCESS of a read -> all outputs 0 immediately; no response afterwards; a new request is accepted normally after release.
- Back-to-back m1 read then write at the same address -> s_ren and s_wen are never high in the same cycle; a GAP cycle separates them; read returns pre-write data.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    GAP
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/sram_arbiter_arb_picker.sv
// Combinational winner selection between the IFU (m0) and LSU (m1).
// Optional macro: ARB_ROUND_ROBIN_EN selects round-robin on contention;
// otherwise the LSU has fixed priority and no last-grant input exists.
module arb_picker
  import sram_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last,
`endif
  input  logic valid0,
  input  logic valid1,
  output logic any,
  output logic pick
);

  // Choose a winner from the two request valids.
  always_comb begin
    any  = valid0 | valid1;
    pick = M_IFU;
`ifdef ARB_ROUND_ROBIN_EN
    if (valid0 && valid1) begin
      pick = ~last;
    end else if (valid1) begin
      pick = M_LSU;
    end
`else
    if (valid1) begin
      pick = M_LSU;
    end
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter and sequencer in front of a level-request SRAM.
// Serialises one access at a time: IDLE -> ACCESS -> RESP -> GAP -> IDLE.
// Optional macro: ARB_ROUND_ROBIN_EN (round-robin instead of LSU priority).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  input  logic                    m0_req_write,
  input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
  input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_req_wstrb,
  output logic                    m0_resp_valid,
  input  logic                    m0_resp_ready,
  output logic [DATA_WIDTH-1:0]   m0_resp_rdata,
  output logic [1:0]              m0_resp_err,
  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  input  logic                    m1_req_write,
  input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
  input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_req_wstrb,
  output logic                    m1_resp_valid,
  input  logic                    m1_resp_ready,
  output logic [DATA_WIDTH-1:0]   m1_resp_rdata,
  output logic [1:0]              m1_resp_err,
  output logic [ADDR_WIDTH-1:0]   s_araddr,
  output logic                    s_ren,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rvalid,
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic                    s_wen,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid
);

  state_t                  state;
  state_t                  state_next;
  logic                    grant;
  logic                    write_lat;
  logic [ADDR_WIDTH-1:0]   addr_lat;
  logic [DATA_WIDTH-1:0]   wdata_lat;
  logic [DATA_WIDTH/8-1:0] wstrb_lat;
  logic [DATA_WIDTH-1:0]   rdata_lat;
  logic [1:0]              err_lat;

  logic pick_any;
  logic pick;
  logic accept;
  logic done;
  logic resp_ready;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Remember the most recently accepted master for round-robin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= M_IFU;
    end else if (accept) begin
      last_grant <= pick;
    end
  end
`endif

  arb_picker u_picker (
`ifdef ARB_ROUND_ROBIN_EN
    .last   (last_grant),
`endif
    .valid0 (m0_req_valid),
    .valid1 (m1_req_valid),
    .any    (pick_any),
    .pick   (pick)
  );

  assign accept     = (state == IDLE) && pick_any;
  assign done       = (state == ACCESS) && (write_lat ? s_bvalid : s_rvalid);
  assign resp_ready = (grant == M_LSU) ? m1_resp_ready : m0_resp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; SRAM delay and response hold time are unbounded.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept)     state_next = ACCESS;
      ACCESS:  if (done)       state_next = RESP;
      RESP:    if (resp_ready) state_next = GAP;
      GAP:                     state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Latch the accepted request and capture the SRAM response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= M_IFU;
      write_lat <= 1'b0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      wstrb_lat <= '0;
      rdata_lat <= '0;
      err_lat   <= RESP_OKAY;
    end else begin
      if (accept) begin
        grant     <= pick;
        write_lat <= (pick == M_LSU) ? m1_req_write : m0_req_write;
        addr_lat  <= (pick == M_LSU) ? m1_req_addr  : m0_req_addr;
        wdata_lat <= (pick == M_LSU) ? m1_req_wdata : m0_req_wdata;
        wstrb_lat <= (pick == M_LSU) ? m1_req_wstrb : m0_req_wstrb;
      end
      if (done) begin
        rdata_lat <= write_lat ? '0 : s_rdata;
        err_lat   <= write_lat ? s_bresp : s_rresp;
      end
    end
  end

  // Outputs decoded from state; ready is gated by reset so everything reads 0 in reset.
  always_comb begin
    m0_req_ready  = rst_n && accept && (pick == M_IFU);
    m1_req_ready  = rst_n && accept && (pick == M_LSU);
    s_ren         = (state == ACCESS) && !write_lat;
    s_wen         = (state == ACCESS) && write_lat;
    s_araddr      = addr_lat;
    s_awaddr      = addr_lat;
    s_wdata       = wdata_lat;
    s_wstrb       = wstrb_lat;
    m0_resp_valid = (state == RESP) && (grant == M_IFU);
    m1_resp_valid = (state == RESP) && (grant == M_LSU);
    m0_resp_rdata = rdata_lat;
    m1_resp_rdata = rdata_lat;
    m0_resp_err   = err_lat;
    m1_resp_err   = err_lat;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a small level-request SRAM model.
module tb_sram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req_valid, m0_req_ready, m0_req_write;
  logic [31:0] m0_req_addr, m0_req_wdata;
  logic [3:0]  m0_req_wstrb;
  logic        m0_resp_valid, m0_resp_ready;
  logic [31:0] m0_resp_rdata;
  logic [1:0]  m0_resp_err;
  logic        m1_req_valid, m1_req_ready, m1_req_write;
  logic [31:0] m1_req_addr, m1_req_wdata;
  logic [3:0]  m1_req_wstrb;
  logic        m1_resp_valid, m1_resp_ready;
  logic [31:0] m1_resp_rdata;
  logic [1:0]  m1_resp_err;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic        s_ren, s_rvalid, s_wen, s_bvalid;
  logic [1:0]  s_rresp, s_bresp;
  logic [3:0]  s_wstrb;

  sram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_write(m0_req_write),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
    .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_write(m1_req_write),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
    .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
    .s_araddr(s_araddr), .s_ren(s_ren), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wen(s_wen), .s_wstrb(s_wstrb),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- SRAM model: response D cycles after request level rises
  logic [31:0] mem [16];
  int          sdelay = 1;
  int          scnt = 0;
  logic [1:0]  rresp_v = 2'b00;
  logic [1:0]  bresp_v = 2'b00;
  logic        load_en = 1'b0;
  logic [3:0]  load_idx = '0;
  logic [31:0] load_val = '0;

  assign s_rresp = rresp_v;
  assign s_bresp = bresp_v;

  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_val;
    if (s_ren || s_wen) begin
      scnt <= scnt + 1;
      if (scnt + 1 >= sdelay) begin
        s_rvalid <= s_ren;
        s_bvalid <= s_wen;
        if (s_ren && !s_rvalid) s_rdata <= mem[s_araddr[5:2]];
        if (s_wen && !s_bvalid) begin
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        end
      end
    end else begin
      scnt     <= 0;
      s_rvalid <= 1'b0;
      s_bvalid <= 1'b0;
    end
  end

  // Read and write requests must never overlap.
  always @(negedge clk) begin
    if (rst_n) chk("ren_wen_exclusive", {63'd0, s_ren && s_wen}, 64'd0);
  end

  // ---------------- helpers
  task automatic load(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    load_en = 1'b1; load_idx = idx; load_val = val;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic drive_req(input int m, input logic v, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    if (m == 0) begin
      m0_req_valid = v; m0_req_write = wr; m0_req_addr = a; m0_req_wdata = wd; m0_req_wstrb = st;
    end else begin
      m1_req_valid = v; m1_req_write = wr; m1_req_addr = a; m1_req_wdata = wd; m1_req_wstrb = st;
    end
  endtask

  function automatic logic req_rdy(input int m);
    return (m == 0) ? m0_req_ready : m1_req_ready;
  endfunction
  function automatic logic rsp_vld(input int m);
    return (m == 0) ? m0_resp_valid : m1_resp_valid;
  endfunction
  function automatic logic [31:0] rsp_data(input int m);
    return (m == 0) ? m0_resp_rdata : m1_resp_rdata;
  endfunction
  function automatic logic [1:0] rsp_err(input int m);
    return (m == 0) ? m0_resp_err : m1_resp_err;
  endfunction
  task automatic set_rsp_rdy(input int m, input logic v);
    if (m == 0) m0_resp_ready = v; else m1_resp_ready = v;
  endtask

  function automatic logic any_out();
    return |{s_ren, s_wen, s_araddr, s_awaddr, s_wdata, s_wstrb,
             m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid,
             m0_resp_rdata, m1_resp_rdata, m0_resp_err, m1_resp_err};
  endfunction

  typedef struct {
    int          m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          d;
    logic [1:0]  err_in;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
  } vec_t;

  // One full transaction with checks on accept, SRAM levels, response and GAP.
  task automatic run_txn(input vec_t v, input string tag);
    int n;
    int ren_c = 0;
    int wen_c = 0;
    bit stable = 1'b1;
    bit got = 1'b0;
    sdelay = v.d; rresp_v = v.err_in; bresp_v = v.err_in;
    @(negedge clk);
    drive_req(v.m, 1'b1, v.wr, v.addr, v.wdata, v.strb);
    #1;
    n = 0;
    while (!req_rdy(v.m) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_accept"}, {63'd0, req_rdy(v.m)}, 64'd1);
    if (!req_rdy(v.m)) begin
      drive_req(v.m, 1'b0, 1'b0, '0, '0, '0);
      return;
    end
    @(negedge clk);
    drive_req(v.m, 1'b0, 1'b0, '0, '0, '0);
    n = 0;
    while (n < 100) begin
      #1;
      if (rsp_vld(v.m)) begin got = 1'b1; break; end
      if (s_ren) begin
        ren_c++;
        if (s_araddr !== v.addr) stable = 1'b0;
      end
      if (s_wen) begin
        wen_c++;
        if (s_awaddr !== v.addr || s_wdata !== v.wdata || s_wstrb !== v.strb) stable = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_resp_seen"}, {63'd0, got}, 64'd1);
    if (!got) return;
    chk({tag, "_rdata"}, {32'd0, rsp_data(v.m)}, {32'd0, v.exp_rdata});
    chk({tag, "_err"}, {62'd0, rsp_err(v.m)}, {62'd0, v.exp_err});
    chk({tag, "_ren_cycles"}, ren_c, v.wr ? 0 : v.d + 1);
    chk({tag, "_wen_cycles"}, wen_c, v.wr ? v.d + 1 : 0);
    chk({tag, "_stable"}, {63'd0, stable}, 64'd1);
    chk({tag, "_resp_other"}, {63'd0, rsp_vld(1 - v.m)}, 64'd0);
    chk({tag, "_resp_sram_idle"}, {62'd0, s_ren, s_wen}, 64'd0);
    set_rsp_rdy(v.m, 1'b1);
    @(negedge clk);
    set_rsp_rdy(v.m, 1'b0);
    #1;
    chk({tag, "_gap"}, {61'd0, s_ren, s_wen, rsp_vld(v.m)}, 64'd0);
  endtask

  vec_t vecs[8];
  int   gnt[6];
  int   gcyc[6];

  initial begin
    int n;
    int k;
    bit ok;
    vec_t v;

    rst_n = 1'b0;
    drive_req(0, 1'b0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0, '0);
    m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    s_rvalid = 1'b0; s_bvalid = 1'b0; s_rdata = '0;

    vecs[0] = '{0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 3, 2'b00, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{1, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 2, 2'b00, 32'h0, 2'b00};
    vecs[2] = '{1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 1, 2'b00, 32'hAABB_5678, 2'b00};
    vecs[3] = '{0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 5, 2'b10, 32'h0BAD_F00D, 2'b10};
    vecs[4] = '{1, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 2, 2'b00, 32'h1111_2222, 2'b00};
    vecs[5] = '{1, 1'b1, 32'h8000_0008, 32'h9988_7766, 4'b1100, 1, 2'b11, 32'h0, 2'b11};
    vecs[6] = '{1, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 4, 2'b00, 32'h9988_2222, 2'b00};
    vecs[7] = '{0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1, 2'b00, 32'h0BAD_F00D, 2'b00};

    load(4'd0, 32'hDEAD_BEEF);
    load(4'd1, 32'h0BAD_F00D);
    load(4'd2, 32'h1111_2222);
    load(4'd4, 32'hAABB_CCDD);
    load(4'd8, 32'h5555_AAAA);

    #1;
    chk("reset_outputs", {63'd0, any_out()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both masters request continuously: grant order and issue spacing (D=2).
    sdelay = 2; rresp_v = 2'b00; bresp_v = 2'b00;
    m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, 32'h8000_0000, '0, '0);
    drive_req(1, 1'b1, 1'b0, 32'h8000_0020, '0, '0);
    k = 0; n = 0;
    while (k < 6 && n < 200) begin
      #1;
      if (m0_req_ready || m1_req_ready) begin
        chk("both_ready", {63'd0, m0_req_ready && m1_req_ready}, 64'd0);
        gnt[k] = m1_req_ready ? 1 : 0;
        gcyc[k] = cyc;
        k++;
      end
      @(negedge clk);
      n++;
    end
    chk("contention_grants", k, 6);
    drive_req(0, 1'b0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < k; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("grant_%0d", i), gnt[i], (i % 2 == 0) ? 1 : 0);
`else
      chk($sformatf("grant_%0d", i), gnt[i], 1);
`endif
      if (i > 0) chk($sformatf("spacing_%0d", i), gcyc[i] - gcyc[i-1], 6);
    end
    repeat (12) @(negedge clk);
    m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;

    // Table of single-master transactions.
    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // m0 response held for 5 cycles while m1 waits.
    sdelay = 2; rresp_v = 2'b00;
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, 32'h8000_0000, '0, '0);
    #1;
    chk("hold_m0_accept", {63'd0, m0_req_ready}, 64'd1);
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b1, 1'b0, 32'h8000_0010, '0, '0);
    n = 0;
    #1;
    while (!m0_resp_valid && n < 50) begin
      chk("hold_m1_blocked_access", {63'd0, m1_req_ready}, 64'd0);
      @(negedge clk); #1; n++;
    end
    chk("hold_resp_seen", {63'd0, m0_resp_valid}, 64'd1);
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (!m0_resp_valid || m0_resp_rdata !== 32'hDEAD_BEEF || m0_resp_err !== 2'b00 ||
          m1_req_ready || m1_resp_valid || s_ren || s_wen) ok = 1'b0;
      @(negedge clk); #1;
    end
    chk("hold_stable", {63'd0, ok}, 64'd1);
    m0_resp_ready = 1'b1;
    @(negedge clk);
    m0_resp_ready = 1'b0;
    #1;
    chk("hold_gap_no_accept", {62'd0, m1_req_ready, m0_resp_valid}, 64'd0);
    @(negedge clk); #1;
    chk("hold_idle_accept", {63'd0, m1_req_ready}, 64'd1);
    @(negedge clk);
    drive_req(1, 1'b0, 1'b0, '0, '0, '0);
    n = 0;
    #1;
    while (!m1_resp_valid && n < 50) begin @(negedge clk); #1; n++; end
    chk("hold_m1_rdata", {32'd0, m1_resp_rdata}, {32'd0, 32'hAABB_5678});
    m1_resp_ready = 1'b1;
    @(negedge clk);
    m1_resp_ready = 1'b0;

    // Asynchronous reset during a read access.
    sdelay = 4;
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, 32'h8000_0004, '0, '0);
    #1;
    chk("rst_accept", {63'd0, m0_req_ready}, 64'd1);
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk); #1;
    chk("rst_in_access", {63'd0, s_ren}, 64'd1);
    m1_req_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {63'd0, any_out()}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    m1_req_valid = 1'b0;
    m0_resp_ready = 1'b1;
    rst_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m0_resp_valid || m1_resp_valid || s_ren || s_wen) ok = 1'b0;
      @(negedge clk);
    end
    m0_resp_ready = 1'b0;
    chk("rst_no_response", {63'd0, ok}, 64'd1);
    v = vecs[0];
    run_txn(v, "post_rst");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
